// File: rtl/fetch_queue_pkg.sv
// Shared fetch-entry definitions so the hart top, the fetch queue and PD agree
// on the bubble instruction and on the {pc, ir, pr_taken, c_ins} packing order.
package fetch_queue_pkg;

  localparam logic [31:0] NOP_IR = 32'h0000_0013;  // addi x0, x0, 0

  localparam int FE_XLEN   = 64;
  localparam int FE_ILEN   = 32;
  localparam int FE_META_W = 2;  // pr_taken, c_ins

  // Packing order, MSB first.
  typedef struct packed {
    logic [FE_XLEN-1:0] pc;
    logic [FE_ILEN-1:0] ir;
    logic               pr_taken;
    logic               c_ins;
  } fetch_entry_t;

  function automatic int entry_width(input int xlen, input int ilen);
    return xlen + ilen + FE_META_W;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Decoupling queue between IF and PD: lets imem keep fetching while PD stalls,
// and empties in one cycle on flush. The head shows a NOP bubble when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = FE_XLEN,
  parameter int ILEN  = FE_ILEN,
  parameter int AFULL = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [ILEN-1:0]        in_ir,
  input  logic                   in_pr_taken,
  input  logic                   in_c_ins,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [ILEN-1:0]        out_ir,
  output logic                   out_pr_taken,
  output logic                   out_c_ins,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = entry_width(XLEN, ILEN);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end
  if (AFULL < 1 || AFULL > DEPTH) begin : g_bad_afull
    $error("fetch_queue: AFULL must lie in 1..DEPTH");
  end

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               empty;
  logic               full;
  logic               enq;
  logic               deq;
  logic [ENTRY_W-1:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign in_ready  = !full;
  assign out_valid = !empty;

  assign enq = in_valid && in_ready && !flush;
  assign deq = out_valid && out_ready && !flush;

  // Array carries no reset; pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr[AW-1:0]] <= {in_pc, in_ir, in_pr_taken, in_c_ins};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
    end
  end

  assign almost_full = (count >= (AW + 1)'(AFULL));

  assign head = mem[rd_ptr[AW-1:0]];

  always_comb begin
    out_pc       = '0;
    out_ir       = ILEN'(NOP_IR);
    out_pr_taken = 1'b0;
    out_c_ins    = 1'b0;
    if (!empty) begin
      out_pc       = head[ENTRY_W-1 -: XLEN];
      out_ir       = head[ILEN+1 -: ILEN];
      out_pr_taken = head[1];
      out_c_ins    = head[0];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue scoreboard of expected head entries.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int AFULL = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] ir;
    logic            pr;
    logic            c;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_pc = '0;
  logic [ILEN-1:0] in_ir = '0;
  logic            in_pr_taken = 1'b0;
  logic            in_c_ins = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_ir;
  logic            out_pr_taken;
  logic            out_c_ins;
  logic [CW-1:0]   count;
  logic            almost_full;

  int   tests = 0;
  int   fails = 0;
  ent_t sb[$];

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN), .AFULL(AFULL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ir(in_ir), .in_pr_taken(in_pr_taken), .in_c_ins(in_c_ins),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ir(out_ir), .out_pr_taken(out_pr_taken), .out_c_ins(out_c_ins),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle: compares every output against the scoreboard model.
  task automatic check_outputs();
    int n;
    n = sb.size();
    chk("out_valid", 128'(out_valid), 128'(n != 0));
    chk("in_ready", 128'(in_ready), 128'(n != DEPTH));
    chk("count", 128'(count), 128'(n));
    chk("almost_full", 128'(almost_full), 128'(n >= AFULL));
    if (n != 0) begin
      chk("head_pc", 128'(out_pc), 128'(sb[0].pc));
      chk("head_ir", 128'(out_ir), 128'(sb[0].ir));
      chk("head_pr", 128'(out_pr_taken), 128'(sb[0].pr));
      chk("head_c", 128'(out_c_ins), 128'(sb[0].c));
    end else begin
      chk("bubble_pc", 128'(out_pc), 128'(0));
      chk("bubble_ir", 128'(out_ir), 128'(32'h13));
      chk("bubble_pr", 128'(out_pr_taken), 128'(0));
      chk("bubble_c", 128'(out_c_ins), 128'(0));
    end
  endtask

  // One clock: drive, check mid-cycle, update model, advance past the edge.
  task automatic cycle(input logic iv, input logic [XLEN-1:0] pc, input logic [ILEN-1:0] ir,
                       input logic pr, input logic c, input logic ordy, input logic fl);
    ent_t e;
    logic do_enq;
    logic do_deq;
    in_valid    = iv;
    in_pc       = pc;
    in_ir       = ir;
    in_pr_taken = pr;
    in_c_ins    = c;
    out_ready   = ordy;
    flush       = fl;
    #4;
    check_outputs();
    do_enq = iv && (sb.size() < DEPTH) && !fl;
    do_deq = ordy && (sb.size() > 0) && !fl;
    if (fl) sb.delete();
    if (do_deq) void'(sb.pop_front());
    if (do_enq) begin
      e.pc = pc; e.ir = ir; e.pr = pr; e.c = c;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [XLEN-1:0] pc);
    cycle(1'b1, pc, {16'hA5A5, pc[15:0]}, pc[2], pc[3], 1'b0, 1'b0);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    logic [XLEN-1:0] pc;

    // Reset then idle
    do_reset();
    idle(1'b0);
    idle(1'b1);

    // Fill and drain
    for (int i = 0; i < 4; i++) push(64'h1000 + 64'(4 * i));
    push(64'h2000);  // refused while full
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b1);

    // Concurrent traffic at count=2, pointers wrap
    push(64'h4000);
    push(64'h4004);
    pc = 64'h4008;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, pc, {16'h5A5A, pc[15:0]}, pc[2], pc[3], 1'b1, 1'b0);
      pc += 4;
    end
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Full with dequeue
    for (int i = 0; i < 4; i++) push(64'h5000 + 64'(4 * i));
    cycle(1'b1, 64'h5010, 32'h0000_5010, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 64'h5010, 32'h0000_5010, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Flush priority
    for (int i = 0; i < 3; i++) push(64'h6000 + 64'(4 * i));
    cycle(1'b1, 64'hDEAD, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    push(64'h7000);
    idle(1'b1);
    idle(1'b0);

    // Compressed / predicted passthrough
    cycle(1'b1, 64'h8002, 32'h0000_4505, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Reset during operation
    push(64'h9000);
    push(64'h9004);
    do_reset();
    idle(1'b1);
    push(64'hA000);
    idle(1'b1);
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
